life_scheduler: RTL and testbench

Generation scheduler for the Game of Life board engines. Decides when the board is randomized, advanced one generation and committed, by issuing one-cycle start pulses to the init, update and copy engines and waiting for their done pulses. Triggers are paced by a speed-selectable interval timer, and every start is aligned to the display vertical sync. It sits between the top-level user inputs and the board engines, and also provides a generation count and a status word.

---
 rtl/life_scheduler.sv | 164 ++++++++++++++++
 tb/tb_life_scheduler.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_scheduler.sv
// Game of Life generation scheduler: paces init/update/copy engine starts off a speed-selectable
// interval timer aligned to vsync. Define LIFE_WDOG_EN to add the engine-timeout watchdog.
module life_scheduler #(
    parameter int CLOCK_FREQ  = 24000000,
    parameter int GEN_W       = 16,
    parameter int TIMER_W     = 25,
    parameter int WDOG_CYCLES = 32768
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    input  logic             randomize,
    input  logic [1:0]       speed,
    input  logic             vsync,
    output logic             init_start,
    output logic             update_start,
    output logic             copy_start,
    input  logic             init_done,
    input  logic             update_done,
    input  logic             copy_done,
    output logic             busy,
    output logic [GEN_W-1:0] generation,
    output logic [2:0]       state,
    output logic             fault
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_VS = 3'd1,
        UPDATE  = 3'd2,
        COPY    = 3'd3,
        INIT    = 3'd4
    } state_t;

    localparam logic [TIMER_W-1:0] LIMIT_0 = TIMER_W'(CLOCK_FREQ / 2 - 1);
    localparam logic [TIMER_W-1:0] LIMIT_1 = TIMER_W'(CLOCK_FREQ / 5 - 1);
    localparam logic [TIMER_W-1:0] LIMIT_2 = TIMER_W'(CLOCK_FREQ / 10 - 1);
    localparam logic [TIMER_W-1:0] LIMIT_3 = TIMER_W'(CLOCK_FREQ / 30 - 1);

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q;
    logic [TIMER_W-1:0] limit;
    logic [GEN_W-1:0]   gen_q;
    logic               vsync_q;
    logic               launch_q;
    logic               busy_q;
    logic               init_start_q, update_start_q, copy_start_q;
    logic               gen_inc, gen_clr;

    always_comb begin
        case (speed)
            2'd0:    limit = LIMIT_0;
            2'd1:    limit = LIMIT_1;
            2'd2:    limit = LIMIT_2;
            default: limit = LIMIT_3;
        endcase
    end

`ifdef LIFE_WDOG_EN
    localparam int                WD_W    = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    localparam logic [WD_W-1:0]   WD_LAST = WD_W'(WDOG_CYCLES - 1);
    logic [WD_W-1:0] wdog_q;
    logic            wdog_trip;
    logic            fault_q;
`else
    // The timeout length only matters in the watchdog build.
    logic unused_wdog;
    assign unused_wdog = (WDOG_CYCLES == 0);
`endif

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        gen_inc = 1'b0;
        gen_clr = 1'b0;
        case (state_q)
            INIT:    if (init_done) begin
                         state_d = IDLE;
                         gen_clr = 1'b1;
                     end
            IDLE:    if (run) begin
                         if (timer_q >= limit) state_d = WAIT_VS;
                     end else if (step) begin
                         state_d = WAIT_VS;
                     end
            WAIT_VS: if (vsync && !vsync_q) state_d = randomize ? INIT : UPDATE;
            UPDATE:  if (update_done) state_d = COPY;
            COPY:    if (copy_done) begin
                         state_d = IDLE;
                         gen_inc = 1'b1;
                     end
            default: state_d = IDLE;
        endcase
`ifdef LIFE_WDOG_EN
        wdog_trip = 1'b0;
        // Abandon an engine that stayed silent for the whole timeout window.
        if ((state_q == INIT || state_q == UPDATE || state_q == COPY) &&
            state_d == state_q && wdog_q == WD_LAST) begin
            state_d   = IDLE;
            wdog_trip = 1'b1;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= INIT;
            timer_q        <= '0;
            gen_q          <= '0;
            vsync_q        <= 1'b0;
            launch_q       <= 1'b1;
            busy_q         <= 1'b1;
            init_start_q   <= 1'b0;
            update_start_q <= 1'b0;
            copy_start_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            vsync_q  <= vsync;
            launch_q <= 1'b0;
            busy_q   <= (state_d == INIT) || (state_d == UPDATE) || (state_d == COPY);

            if (state_q == IDLE && state_d != IDLE) timer_q <= '0;
            else if (state_q == IDLE && run)        timer_q <= timer_q + 1'b1;

            if (gen_clr)      gen_q <= '0;
            else if (gen_inc) gen_q <= gen_q + 1'b1;

            // The first cycle after reset counts as an INIT entry.
            init_start_q   <= (state_d == INIT) && (state_q != INIT || launch_q);
            update_start_q <= (state_d == UPDATE) && (state_q != UPDATE);
            copy_start_q   <= (state_d == COPY) && (state_q != COPY);
        end
    end

`ifdef LIFE_WDOG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            if (state_d != state_q)
                wdog_q <= '0;
            else if (state_q == INIT || state_q == UPDATE || state_q == COPY)
                wdog_q <= wdog_q + 1'b1;

            if (wdog_trip)                         fault_q <= 1'b1;
            else if (state_q == INIT && init_done) fault_q <= 1'b0;
        end
    end
    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    assign state        = state_q;
    assign busy         = busy_q;
    assign generation   = gen_q;
    assign init_start   = init_start_q;
    assign update_start = update_start_q;
    assign copy_start   = copy_start_q;

endmodule

// File: tb/tb_life_scheduler.sv
// Randomized scoreboard bench for life_scheduler: the driver predicts every state entry from the
// scheduling rules and queues it; a negedge monitor pops and compares each observed entry.
module tb_life_scheduler;

    localparam int CF = 300;
    localparam int GW = 4;
    localparam int WD = 64;

    typedef struct {
        logic [2:0] st;
        int         gen;
        int         cyc;
    } exp_t;

    logic          clk = 1'b0, reset = 1'b1;
    logic          run = 1'b0, step = 1'b0, randomize = 1'b0, vsync = 1'b0;
    logic [1:0]    speed = 2'd0;
    logic          init_done = 1'b0, update_done = 1'b0, copy_done = 1'b0;
    logic          init_start, update_start, copy_start, busy, fault;
    logic [GW-1:0] generation;
    logic [2:0]    state;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         gen_m = 0;
    logic [2:0] prev_st = 3'd4;

    life_scheduler #(
        .CLOCK_FREQ(CF), .GEN_W(GW), .TIMER_W(9), .WDOG_CYCLES(WD)
    ) dut (
        .clk(clk), .reset(reset), .run(run), .step(step), .randomize(randomize),
        .speed(speed), .vsync(vsync),
        .init_start(init_start), .update_start(update_start), .copy_start(copy_start),
        .init_done(init_done), .update_done(update_done), .copy_done(copy_done),
        .busy(busy), .generation(generation), .state(state), .fault(fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int interval(input int s);
        case (s)
            0:       return CF / 2;
            1:       return CF / 5;
            2:       return CF / 10;
            default: return CF / 30;
        endcase
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Start pulse expected on entry to a state: init/update/copy, none for IDLE or WAIT_VS.
    function automatic int entry_starts(input logic [2:0] st);
        case (st)
            3'd4:    return 4;
            3'd2:    return 2;
            3'd3:    return 1;
            default: return 0;
        endcase
    endfunction

    task automatic expect_entry(input logic [2:0] st, input int gen, input int c);
        exp_t x;
        x.st  = st;
        x.gen = gen;
        x.cyc = c;
        sb.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Random vsync activity plus done pulses that do not belong to state st.
    task automatic noise(input logic [2:0] st);
        vsync       = ($urandom_range(0, 1) == 1);
        init_done   = (st != 3'd4) && ($urandom_range(0, 4) == 0);
        update_done = (st != 3'd2) && ($urandom_range(0, 4) == 0);
        copy_done   = (st != 3'd3) && ($urandom_range(0, 4) == 0);
    endtask

    // Entered at the first IDLE cycle; returns at the first WAIT_VS cycle.
    task automatic idle_phase();
        int e, g, mode, s1, s2, m, target;
        e    = cyc;
        g    = $urandom_range(0, 3);
        mode = $urandom_range(0, 3);   // 0 step, 1 speed change, 2 plain run, 3 run with step
        s1   = $urandom_range(0, 3);
        s2   = (mode == 1) ? $urandom_range(0, 3) : s1;
        m    = (mode == 1) ? $urandom_range(0, interval(s1) - 1) : 0;
        target = (mode == 0) ? e + g + 1 : e + g + max2(m + 1, interval(s2));
        expect_entry(3'd1, gen_m, target);
        while (cyc < target) begin
            noise(3'd0);
            run   = (mode != 0) && (cyc >= e + g);
            step  = (cyc == e + g) && (mode == 0 || mode == 3);
            speed = 2'((cyc - (e + g) >= m) ? s2 : s1);
            tick();
        end
        step = 1'b0;
    endtask

    // Entered at the first WAIT_VS cycle; force_r < 0 picks randomize at random.
    task automatic waitvs_phase(input int force_r, output int r);
        int   h;
        logic v;
        v = vsync;
        h = $urandom_range(0, 4);
        r = (force_r >= 0) ? force_r : int'($urandom_range(0, 3) == 0);
        repeat (h) begin
            noise(3'd1);
            vsync     = v;
            randomize = ($urandom_range(0, 1) == 1);
            run       = ($urandom_range(0, 1) == 1);
            tick();
        end
        noise(3'd1);
        vsync = 1'b0;
        run   = ($urandom_range(0, 1) == 1);
        tick();
        noise(3'd1);
        vsync     = 1'b1;
        randomize = (r != 0);
        expect_entry((r != 0) ? 3'd4 : 3'd2, gen_m, cyc + 1);
        tick();
        randomize = 1'b0;
    endtask

    // Entered at the first cycle of INIT/UPDATE/COPY; answers with the done pulse after 0-3 cycles.
    task automatic engine_phase(input logic [2:0] st);
        int         r;
        logic [2:0] nxt;
        r = $urandom_range(0, 3);
        repeat (r) begin
            noise(st);
            run = ($urandom_range(0, 1) == 1);
            tick();
        end
        noise(st);
        case (st)
            3'd4: begin init_done = 1'b1;   nxt = 3'd0; gen_m = 0; end
            3'd2: begin update_done = 1'b1; nxt = 3'd3; end
            default: begin copy_done = 1'b1; nxt = 3'd0; gen_m = (gen_m + 1) % (1 << GW); end
        endcase
        expect_entry(nxt, gen_m, cyc + 1);
        tick();
    endtask

    task automatic reset_mid();
        @(negedge clk);
        #2;
        reset = 1'b1;
        {run, step, randomize, init_done, update_done, copy_done} = '0;
        #1;
        check("midreset_state", state, 4);
        check("midreset_busy", busy, 1);
        check("midreset_generation", generation, 0);
        check("midreset_starts", {init_start, update_start, copy_start}, 0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        gen_m = 0;
        expect_entry(3'd4, 0, 1);
        tick();
        engine_phase(3'd4);
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (reset) begin
            prev_st = 3'd4;
        end else begin
            if (state !== prev_st || {init_start, update_start, copy_start} != 3'b000) begin
                if (sb.size() == 0) begin
                    check("unexpected_event_state", state, prev_st);
                end else begin
                    x = sb.pop_front();
                    check("entry_state", state, x.st);
                    check("entry_cycle", cyc, x.cyc);
                    check("entry_generation", generation, x.gen);
                    check("entry_starts", {init_start, update_start, copy_start}, entry_starts(x.st));
                    check("entry_busy", busy, int'(x.st >= 3'd2));
                end
            end
            prev_st = state;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int r;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", state, 4);
        check("reset_busy", busy, 1);
        check("reset_generation", generation, 0);
        check("reset_starts", {init_start, update_start, copy_start}, 0);
        check("reset_fault", fault, 0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        expect_entry(3'd4, 0, 1);
        tick();
        engine_phase(3'd4);

        // Long update-only run so the 4-bit generation count wraps.
        for (int i = 0; i < 18; i++) begin
            idle_phase();
            waitvs_phase(0, r);
            engine_phase(3'd2);
            engine_phase(3'd3);
        end

        for (int i = 0; i < 14; i++) begin
            idle_phase();
            waitvs_phase(-1, r);
            if (r != 0) begin
                engine_phase(3'd4);
            end else if (i == 6) begin
                reset_mid();
            end else begin
                engine_phase(3'd2);
                engine_phase(3'd3);
            end
        end

`ifdef LIFE_WDOG_EN
        begin
            int e;
            idle_phase();
            waitvs_phase(0, r);
            e = cyc;
            check("wdog_fault_before", fault, 0);
            expect_entry(3'd0, gen_m, e + WD);
            repeat (WD) begin
                noise(3'd2);
                tick();
            end
            check("wdog_fault_set", fault, 1);
            idle_phase();
            waitvs_phase(1, r);
            engine_phase(3'd4);
            check("wdog_fault_cleared", fault, 0);
        end
`else
        check("fault_tied_low", fault, 0);
`endif

        for (int k = 0; k < 8 && sb.size() != 0; k++) tick();
        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
